// File: rtl/csr_encoder_pkg.sv
// Shared widths and FSM encoding for the dense-to-CSR writer.
package csr_pkg;
  localparam int DATA_W = 32;
  localparam int NNZ_AW = 14;
  localparam int ROW_AW = 10;
  localparam int COL_W  = 10;

  typedef enum logic [1:0] {IDLE, PTR0, STREAM, FIN} state_e;
endpackage

// File: rtl/csr_encoder_if.sv
// Element stream plus the three CSR RAM write ports of csr_encoder.
interface csr_encoder_if #(parameter int DATA_W = 32);
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_W-1:0]           in_data;
  logic                        val_we;
  logic [csr_pkg::NNZ_AW-1:0]  val_addr;
  logic [DATA_W-1:0]           val_din;
  logic                        col_we;
  logic [csr_pkg::NNZ_AW-1:0]  col_addr;
  logic [31:0]                 col_din;
  logic                        row_we;
  logic [csr_pkg::ROW_AW-1:0]  row_addr;
  logic [31:0]                 row_din;

  // master = encoder side, slave = stream source / RAM side
  modport master (input in_valid, in_data,
                  output in_ready, val_we, val_addr, val_din, col_we, col_addr, col_din,
                  row_we, row_addr, row_din);
  modport slave  (output in_valid, in_data,
                  input in_ready, val_we, val_addr, val_din, col_we, col_addr, col_din,
                  row_we, row_addr, row_din);
endinterface

// File: rtl/csr_encoder_classifier.sv
// Zero/nonzero decision for one dense element. CSR_ZERO_THRESH_EN selects
// magnitude-vs-threshold instead of exact zero.
module csr_elem_classifier #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
`ifdef CSR_ZERO_THRESH_EN
  input  logic [DATA_W-1:0] thresh,
`endif
  output logic              is_nonzero
);
`ifdef CSR_ZERO_THRESH_EN
  logic [DATA_W-1:0] neg, mag;

  // Negating the most negative value wraps to itself; clamp it to +max instead.
  always_comb begin
    neg = -data;
    if (!data[DATA_W-1])    mag = data;
    else if (neg[DATA_W-1]) mag = {1'b0, {(DATA_W-1){1'b1}}};
    else                    mag = neg;
  end

  assign is_nonzero = mag > thresh;
`else
  assign is_nonzero = |data;
`endif
endmodule

// File: rtl/csr_encoder.sv
// Dense row-major stream -> CSR value/col/row_ptr RAM writes. Optional
// CSR_ZERO_THRESH_EN adds a thresh port for near-zero dropping.
module csr_encoder #(
  parameter int DATA_W  = csr_pkg::DATA_W,
  parameter int N_ROWS  = 560,
  parameter int N_COLS  = 560,
  parameter int NNZ_MAX = 16384
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef CSR_ZERO_THRESH_EN
  input  logic [DATA_W-1:0]  thresh,
`endif
  csr_encoder_if.master      bus,
  output logic               busy,
  output logic               done,
  output logic [14:0]        nnz,
  output logic               overflow
);
  import csr_pkg::*;

  localparam logic [14:0]       NNZ_LIM  = 15'(NNZ_MAX);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(N_COLS - 1);
  localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(N_ROWS - 1);

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q;
  logic [ROW_AW-1:0]   row_q;
  logic [14:0]         nnz_q, nnz_nxt;
  logic                ovf_q, done_q;
  logic                val_we_q, row_we_q;
  logic [NNZ_AW-1:0]   val_addr_q;
  logic [DATA_W-1:0]   val_din_q;
  logic [COL_W-1:0]    col_din_q;
  logic [ROW_AW-1:0]   row_addr_q;
  logic [14:0]         row_din_q;
  logic                is_nz, accept, store, last_col, last_row;

  csr_elem_classifier #(.DATA_W(DATA_W)) u_cls (
    .data       (bus.in_data),
`ifdef CSR_ZERO_THRESH_EN
    .thresh     (thresh),
`endif
    .is_nonzero (is_nz)
  );

  assign accept   = (state_q == STREAM) && bus.in_valid;
  assign store    = accept && is_nz && (nnz_q < NNZ_LIM);
  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);
  assign nnz_nxt  = nnz_q + {14'd0, store};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = PTR0;
      PTR0:    state_d = STREAM;
      STREAM:  if (accept && last_col && last_row) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write strobes are one-cycle registered pulses; done trails the FIN writes by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      nnz_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      val_we_q   <= 1'b0;
      val_addr_q <= '0;
      val_din_q  <= '0;
      col_din_q  <= '0;
      row_we_q   <= 1'b0;
      row_addr_q <= '0;
      row_din_q  <= '0;
    end else begin
      val_we_q <= 1'b0;
      row_we_q <= 1'b0;
      done_q   <= (state_q == FIN);
      unique case (state_q)
        IDLE: if (start) begin
          row_we_q   <= 1'b1;
          row_addr_q <= '0;
          row_din_q  <= '0;
          nnz_q      <= '0;
          ovf_q      <= 1'b0;
          col_q      <= '0;
          row_q      <= '0;
        end
        STREAM: if (accept) begin
          if (store) begin
            val_we_q   <= 1'b1;
            val_addr_q <= nnz_q[NNZ_AW-1:0];
            val_din_q  <= bus.in_data;
            col_din_q  <= col_q;
          end
          if (is_nz && !store) ovf_q <= 1'b1;
          nnz_q <= nnz_nxt;
          if (last_col) begin
            row_we_q   <= 1'b1;
            row_addr_q <= row_q + ROW_AW'(1);
            row_din_q  <= nnz_nxt;
            col_q      <= '0;
            row_q      <= last_row ? '0 : row_q + ROW_AW'(1);
          end else begin
            col_q <= col_q + COL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // rst masks strobes combinationally so a write in flight never reaches the RAMs.
  assign bus.in_ready = (state_q == STREAM) && !rst;
  assign bus.val_we   = val_we_q && !rst;
  assign bus.col_we   = val_we_q && !rst;
  assign bus.val_addr = val_addr_q;
  assign bus.col_addr = val_addr_q;
  assign bus.val_din  = val_din_q;
  assign bus.col_din  = {{(32-COL_W){1'b0}}, col_din_q};
  assign bus.row_we   = row_we_q && !rst;
  assign bus.row_addr = row_addr_q;
  assign bus.row_din  = {17'd0, row_din_q};
  assign busy         = (state_q != IDLE) && !rst;
  assign done         = done_q && !rst;
  assign nnz          = nnz_q;
  assign overflow     = ovf_q;
endmodule
